// File: rtl/battleship_ctrl.sv
// Two-player battleship game controller: placement, turns, shot resolution.
// Define BATTLESHIP_TIMEOUT_EN to add the per-turn timeout that passes the turn.
module battleship_ctrl #(
  parameter int N           = 5,
  parameter int SHIPS       = 5,
  parameter int TURN_CYCLES = 255,
  localparam int CW = (N > 1) ? $clog2(N) : 1,
  localparam int SW = $clog2(SHIPS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_game,
  input  logic          place_valid,
  input  logic          fire,
  input  logic [CW-1:0] row_in,
  input  logic [CW-1:0] col_in,
  output logic [2:0]    state_o,
  output logic          cur_player,
  output logic          hit_feedback,
  output logic          miss_feedback,
  output logic          err_pulse,
  output logic [SW-1:0] ships_p0,
  output logic [SW-1:0] ships_p1,
  output logic          game_over,
  output logic          winner
);

  localparam int CELLS = N * N;
  localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLACE_P0  = 3'd1,
    PLACE_P1  = 3'd2,
    TURN      = 3'd3,
    RESOLVE   = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  if (N < 2 || N > 16 || SHIPS < 1 || SHIPS > N * N || TURN_CYCLES < 2)
  begin : g_bad_param
    $error("battleship_ctrl: parameter out of range");
  end

  state_t               state;
  logic [1:0][CELLS-1:0] ship_map;
  logic [1:0][CELLS-1:0] shot_map;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        tgt;
  logic                 in_range;
  logic                 place_ok;
  logic                 fire_ok;
  logic                 opp_ship;
  logic [SW-1:0]        opp_cnt;
  logic                 restart;

`ifdef BATTLESHIP_TIMEOUT_EN
  localparam int TW = $clog2(TURN_CYCLES);
  logic [TW-1:0] timer;
`endif

  assign state_o = state;

  always_comb begin
    in_range = (int'(row_in) < N) && (int'(col_in) < N);
    idx      = IW'(row_in) * IW'(N) + IW'(col_in);
    place_ok = place_valid && in_range && !ship_map[cur_player][idx];
    fire_ok  = fire && in_range && !shot_map[cur_player][idx];
    opp_ship = ship_map[~cur_player][tgt];
    opp_cnt  = cur_player ? ships_p0 : ships_p1;
    restart  = start_game && (state == IDLE || state == GAME_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ship_map      <= '0;
      shot_map      <= '0;
      tgt           <= '0;
      cur_player    <= 1'b0;
      hit_feedback  <= 1'b0;
      miss_feedback <= 1'b0;
      err_pulse     <= 1'b0;
      ships_p0      <= '0;
      ships_p1      <= '0;
      game_over     <= 1'b0;
      winner        <= 1'b0;
`ifdef BATTLESHIP_TIMEOUT_EN
      timer         <= '0;
`endif
    end else begin
      hit_feedback  <= 1'b0;
      miss_feedback <= 1'b0;
      err_pulse     <= 1'b0;
      if (restart) begin
        state      <= PLACE_P0;
        ship_map   <= '0;
        shot_map   <= '0;
        cur_player <= 1'b0;
        ships_p0   <= '0;
        ships_p1   <= '0;
        game_over  <= 1'b0;
        winner     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          PLACE_P0: begin
            if (place_ok) begin
              ship_map[0][idx] <= 1'b1;
              ships_p0         <= ships_p0 + 1'b1;
              if (ships_p0 == SW'(SHIPS - 1)) begin
                state      <= PLACE_P1;
                cur_player <= 1'b1;
              end
            end else if (place_valid) begin
              err_pulse <= 1'b1;
            end
          end
          PLACE_P1: begin
            if (place_ok) begin
              ship_map[1][idx] <= 1'b1;
              ships_p1         <= ships_p1 + 1'b1;
              if (ships_p1 == SW'(SHIPS - 1)) begin
                state      <= TURN;
                cur_player <= 1'b0;
              end
            end else if (place_valid) begin
              err_pulse <= 1'b1;
            end
          end
          TURN: begin
            if (fire_ok) begin
              tgt                       <= idx;
              shot_map[cur_player][idx] <= 1'b1;
              state                     <= RESOLVE;
            end else if (fire) begin
              err_pulse <= 1'b1;
            end
          end
          RESOLVE: begin
            if (opp_ship) begin
              hit_feedback <= 1'b1;
              if (cur_player) begin
                if (ships_p0 != '0) ships_p0 <= ships_p0 - 1'b1;
              end else begin
                if (ships_p1 != '0) ships_p1 <= ships_p1 - 1'b1;
              end
              // last unsunk cell of the opponent ends the game
              if (opp_cnt <= SW'(1)) begin
                state     <= GAME_OVER;
                game_over <= 1'b1;
                winner    <= cur_player;
              end else begin
                state <= TURN;
              end
            end else begin
              miss_feedback <= 1'b1;
              cur_player    <= ~cur_player;
              state         <= TURN;
            end
          end
          GAME_OVER: ;
          default: state <= IDLE;
        endcase
      end
`ifdef BATTLESHIP_TIMEOUT_EN
      // timer only runs while waiting for a legal shot
      if (state == TURN && !fire_ok) begin
        if (timer == TW'(TURN_CYCLES - 1)) begin
          timer      <= '0;
          cur_player <= ~cur_player;
          err_pulse  <= 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
      end else begin
        timer <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_battleship_ctrl.sv
// Self-checking bench for battleship_ctrl (N=5, SHIPS=3, TURN_CYCLES=16).
// Shot results are checked through a scoreboard keyed on expected cycle.
module tb_battleship_ctrl;

  localparam int N  = 5;
  localparam int SH = 3;
  localparam int TC = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_game = 1'b0;
  logic       place_valid = 1'b0;
  logic       fire = 1'b0;
  logic [2:0] row_in = '0;
  logic [2:0] col_in = '0;
  logic [2:0] state_o;
  logic       cur_player;
  logic       hit_feedback;
  logic       miss_feedback;
  logic       err_pulse;
  logic [1:0] ships_p0;
  logic [1:0] ships_p1;
  logic       game_over;
  logic       winner;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic hit;
    int   due;
  } exp_t;
  exp_t sb[$];

  battleship_ctrl #(.N(N), .SHIPS(SH), .TURN_CYCLES(TC)) dut (
    .clk(clk), .rst(rst), .start_game(start_game),
    .place_valid(place_valid), .fire(fire),
    .row_in(row_in), .col_in(col_in), .state_o(state_o),
    .cur_player(cur_player), .hit_feedback(hit_feedback),
    .miss_feedback(miss_feedback), .err_pulse(err_pulse),
    .ships_p0(ships_p0), .ships_p1(ships_p1),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (hit_feedback || miss_feedback)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_feedback: hit=%0b miss=%0b, want none",
                 hit_feedback, miss_feedback);
      end else begin
        e = sb.pop_front();
        if (hit_feedback !== e.hit || miss_feedback !== !e.hit
            || cyc !== e.due) begin
          errors++;
          $display("FAIL shot_result: hit=%0b miss=%0b cyc=%0d, want hit=%0b cyc=%0d",
                   hit_feedback, miss_feedback, cyc, e.hit, e.due);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic place(input int r, input int c);
    row_in = 3'(r);
    col_in = 3'(c);
    place_valid = 1'b1;
    tick();
    place_valid = 1'b0;
  endtask

  task automatic shoot(input int r, input int c, input logic hit);
    exp_t e;
    e.hit = hit;
    e.due = cyc + 2;
    sb.push_back(e);
    row_in = 3'(r);
    col_in = 3'(c);
    fire = 1'b1;
    tick();
    fire = 1'b0;
    checks++;
    if (state_o !== 3'd4) begin
      errors++;
      $display("FAIL resolve_state: got %0d, want 4", state_o);
    end
    tick();
  endtask

  task automatic fire_bad(input int r, input int c);
    row_in = 3'(r);
    col_in = 3'(c);
    fire = 1'b1;
    tick();
    fire = 1'b0;
    checks++;
    if (err_pulse !== 1'b1 || state_o !== 3'd3) begin
      errors++;
      $display("FAIL fire_reject(%0d,%0d): err=%0b state=%0d, want err=1 state=3",
               r, c, err_pulse, state_o);
    end
  endtask

  task automatic new_game();
    start_game = 1'b1;
    tick();
    start_game = 1'b0;
    checks++;
    if (state_o !== 3'd1 || ships_p0 !== 2'd0 || ships_p1 !== 2'd0
        || cur_player !== 1'b0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL new_game: state=%0d p0=%0d p1=%0d cur=%0b go=%0b, want 1 0 0 0 0",
               state_o, ships_p0, ships_p1, cur_player, game_over);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_game = 1'b1;
    tick();
    tick();
    start_game = 1'b0;
    checks++;
    if (state_o !== 3'd0 || cur_player !== 1'b0 || hit_feedback !== 1'b0
        || miss_feedback !== 1'b0 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: state=%0d cur=%0b pulses=%0b%0b%0b, want 0 0 000",
               state_o, cur_player, hit_feedback, miss_feedback, err_pulse);
    end
    checks++;
    if (ships_p0 !== 2'd0 || ships_p1 !== 2'd0 || game_over !== 1'b0
        || winner !== 1'b0) begin
      errors++;
      $display("FAIL reset_counts: p0=%0d p1=%0d go=%0b win=%0b, want 0 0 0 0",
               ships_p0, ships_p1, game_over, winner);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL idle_hold: state=%0d, want 0", state_o);
    end
  endtask

  task automatic test_placement();
    new_game();
    place(0, 0);
    checks++;
    if (err_pulse !== 1'b0 || ships_p0 !== 2'd1) begin
      errors++;
      $display("FAIL place_first: err=%0b p0=%0d, want 0 1", err_pulse, ships_p0);
    end
    place(0, 0);
    checks++;
    if (err_pulse !== 1'b1 || ships_p0 !== 2'd1) begin
      errors++;
      $display("FAIL place_dup: err=%0b p0=%0d, want 1 1", err_pulse, ships_p0);
    end
    place(5, 1);
    checks++;
    if (err_pulse !== 1'b1 || ships_p0 !== 2'd1) begin
      errors++;
      $display("FAIL place_row_oob: err=%0b p0=%0d, want 1 1", err_pulse, ships_p0);
    end
    place(0, 7);
    checks++;
    if (err_pulse !== 1'b1 || ships_p0 !== 2'd1) begin
      errors++;
      $display("FAIL place_col_oob: err=%0b p0=%0d, want 1 1", err_pulse, ships_p0);
    end
    fire = 1'b1;
    tick();
    fire = 1'b0;
    checks++;
    if (err_pulse !== 1'b0 || state_o !== 3'd1) begin
      errors++;
      $display("FAIL fire_in_place: err=%0b state=%0d, want 0 1", err_pulse, state_o);
    end
    place(0, 1);
    place(0, 2);
    checks++;
    if (state_o !== 3'd2 || cur_player !== 1'b1 || ships_p0 !== 2'd3) begin
      errors++;
      $display("FAIL to_place_p1: state=%0d cur=%0b p0=%0d, want 2 1 3",
               state_o, cur_player, ships_p0);
    end
    place(4, 4);
    place(4, 4);
    checks++;
    if (err_pulse !== 1'b1 || ships_p1 !== 2'd1) begin
      errors++;
      $display("FAIL p1_dup: err=%0b p1=%0d, want 1 1", err_pulse, ships_p1);
    end
    place(3, 3);
    fire = 1'b1;
    place(2, 2);
    fire = 1'b0;
    checks++;
    if (state_o !== 3'd3 || cur_player !== 1'b0 || ships_p0 !== 2'd3
        || ships_p1 !== 2'd3 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL to_turn: state=%0d cur=%0b p0=%0d p1=%0d err=%0b, want 3 0 3 3 0",
               state_o, cur_player, ships_p0, ships_p1, err_pulse);
    end
  endtask

  task automatic test_hit_miss();
    shoot(4, 4, 1'b1);
    checks++;
    if (ships_p1 !== 2'd2 || cur_player !== 1'b0 || state_o !== 3'd3) begin
      errors++;
      $display("FAIL p0_hit: p1=%0d cur=%0b state=%0d, want 2 0 3",
               ships_p1, cur_player, state_o);
    end
    shoot(1, 1, 1'b0);
    checks++;
    if (cur_player !== 1'b1 || ships_p1 !== 2'd2) begin
      errors++;
      $display("FAIL p0_miss: cur=%0b p1=%0d, want 1 2", cur_player, ships_p1);
    end
    shoot(0, 0, 1'b1);
    checks++;
    if (ships_p0 !== 2'd2 || cur_player !== 1'b1) begin
      errors++;
      $display("FAIL p1_hit: p0=%0d cur=%0b, want 2 1", ships_p0, cur_player);
    end
    fire_bad(0, 0);
    fire_bad(5, 0);
    place(1, 3);
    checks++;
    if (err_pulse !== 1'b0 || ships_p1 !== 2'd2 || state_o !== 3'd3) begin
      errors++;
      $display("FAIL place_in_turn: err=%0b p1=%0d state=%0d, want 0 2 3",
               err_pulse, ships_p1, state_o);
    end
    shoot(4, 0, 1'b0);
    checks++;
    if (cur_player !== 1'b0) begin
      errors++;
      $display("FAIL p1_miss: cur=%0b, want 0", cur_player);
    end
    fire_bad(1, 1);
  endtask

  task automatic test_game_over();
    shoot(3, 3, 1'b1);
    shoot(2, 2, 1'b1);
    checks++;
    if (state_o !== 3'd5 || game_over !== 1'b1 || winner !== 1'b0
        || ships_p1 !== 2'd0) begin
      errors++;
      $display("FAIL game_over: state=%0d go=%0b win=%0b p1=%0d, want 5 1 0 0",
               state_o, game_over, winner, ships_p1);
    end
    row_in = 3'd1;
    col_in = 3'd2;
    fire = 1'b1;
    tick();
    fire = 1'b0;
    tick();
    checks++;
    if (state_o !== 3'd5 || err_pulse !== 1'b0 || game_over !== 1'b1
        || ships_p0 !== 2'd2) begin
      errors++;
      $display("FAIL over_hold: state=%0d err=%0b go=%0b p0=%0d, want 5 0 1 2",
               state_o, err_pulse, game_over, ships_p0);
    end
  endtask

  task automatic test_timeout();
    int found;
    int errs;
    new_game();
    place(0, 0); place(0, 1); place(0, 2);
    place(4, 4); place(3, 3); place(2, 2);
    found = 0;
    errs = 0;
`ifdef BATTLESHIP_TIMEOUT_EN
    for (int i = 1; i <= 40 && found == 0; i++) begin
      tick();
      if (err_pulse) found = i;
    end
    checks++;
    if (found !== TC || cur_player !== 1'b1 || state_o !== 3'd3) begin
      errors++;
      $display("FAIL timeout: after=%0d cur=%0b state=%0d, want %0d 1 3",
               found, cur_player, state_o, TC);
    end
    shoot(0, 0, 1'b1);
`else
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (err_pulse) errs++;
    end
    checks++;
    if (errs !== 0 || cur_player !== 1'b0 || state_o !== 3'd3) begin
      errors++;
      $display("FAIL no_timeout: errs=%0d cur=%0b state=%0d, want 0 0 3",
               errs, cur_player, state_o);
    end
`endif
  endtask

  task automatic test_rst_resolve();
    row_in = 3'd1;
    col_in = 3'd4;
    fire = 1'b1;
    tick();
    fire = 1'b0;
    checks++;
    if (state_o !== 3'd4) begin
      errors++;
      $display("FAIL rst_pre: state=%0d, want 4", state_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (state_o !== 3'd0 || ships_p0 !== 2'd0 || ships_p1 !== 2'd0
        || cur_player !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: state=%0d p0=%0d p1=%0d cur=%0b, want 0 0 0 0",
               state_o, ships_p0, ships_p1, cur_player);
    end
    tick();
    tick();
    checks++;
    if (hit_feedback !== 1'b0 || miss_feedback !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_pulse: hit=%0b miss=%0b, want 0 0",
               hit_feedback, miss_feedback);
    end
    rst = 1'b0;
    tick();
    new_game();
    place(0, 0);
    checks++;
    if (err_pulse !== 1'b0 || ships_p0 !== 2'd1) begin
      errors++;
      $display("FAIL rst_cleared_map: err=%0b p0=%0d, want 0 1", err_pulse, ships_p0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_placement();
    test_hit_miss();
    test_game_over();
    test_timeout();
    test_rst_resolve();
    tick();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL missing_feedback: pending=%0d, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/battleship_ctrl.md
BATTLESHIP_CTRL -- requirements
Module: battleship_ctrl

Interface
REQ-001 Parameter N, default 5, board side length in cells (2..16).
REQ-002 Parameter SHIPS, default 5, ship cells per player (1..N*N).
REQ-003 Parameter TURN_CYCLES, default 255, turn timeout in clock cycles (>=2).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start_game  in  1  level, starts or restarts a game from IDLE or GAME_OVER.
REQ-007 place_valid  in  1  one-cycle ship-cell placement request.
REQ-008 fire  in  1  one-cycle shot request.
REQ-009 row_in, col_in  in  CW each  target cell; CW = $clog2(N), minimum 1.
REQ-010 state_o  out  3  IDLE=0, PLACE_P0=1, PLACE_P1=2, TURN=3, RESOLVE=4, GAME_OVER=5.
REQ-011 cur_player  out  1  player placing or firing.
REQ-012 hit_feedback, miss_feedback  out  1 each  one-cycle shot result pulses.
REQ-013 err_pulse  out  1  one-cycle pulse on a rejected place or fire request.
REQ-014 ships_p0, ships_p1  out  SW each  remaining ship cells; SW = $clog2(SHIPS+1).
REQ-015 game_over  out  1  high while in GAME_OVER.
REQ-016 winner  out  1  winning player, valid while game_over is high.

Function
REQ-017 Storage: two N*N ship bitmaps and two N*N shot bitmaps, indexed row*N+col.
REQ-018 IDLE: start_game high -> PLACE_P0; clear all bitmaps; cur_player=0; ships_p0=ships_p1=0.
REQ-019 PLACE_Px, legal request (place_valid, row_in<N, col_in<N, cell empty in own map): set the bit and increment ships_px.
REQ-020 PLACE_Px, illegal request (out of range or duplicate cell): assert err_pulse; leave maps and counts unchanged.
REQ-021 PLACE_Px, count reaches SHIPS on an edge: PLACE_P0 -> PLACE_P1 (cur_player=1); PLACE_P1 -> TURN (cur_player=0).
REQ-022 TURN: fire with in-range coordinates not yet in the shooter's shot map -> latch coordinates, set shot bit, go to RESOLVE.
REQ-023 TURN: fire out of range or on an already-shot cell -> assert err_pulse; stay in TURN; timer keeps running.
REQ-024 RESOLVE lasts exactly one cycle; on leaving it, test the opponent's ship bit at the latched cell.
REQ-025 On a hit: hit_feedback pulses; decrement the opponent's count; same player keeps the turn.
REQ-026 On a miss: miss_feedback pulses; toggle cur_player.
REQ-027 Shot latency: fire sampled at edge k -> feedback pulse high during the cycle after edge k+1.
REQ-028 Opponent count reaching 0 -> GAME_OVER instead of TURN; winner=cur_player; game_over=1.
REQ-029 GAME_OVER: hold all outputs; start_game -> PLACE_P0 with the same clearing as REQ-018.
REQ-030 place_valid outside PLACE states, and fire outside TURN, are ignored with no err_pulse.
REQ-031 place_valid and fire together in one cycle: only the request valid for the current state is acted on.
REQ-032 Counts never underflow; decrement happens only on a hit to an unsunk ship cell.

Reset
REQ-033 rst high, at any time including mid-game: state IDLE, cur_player=0, all pulses 0, counts 0, game_over=0, winner=0, timer 0, bitmaps cleared.
REQ-034 The first functional edge follows deassertion of rst; start_game must be high on that edge to leave IDLE.

Configuration
REQ-035 Macro BATTLESHIP_TIMEOUT_EN defined: timer counts in TURN and clears on entry to TURN and on any accepted fire.
REQ-036 With the macro defined: timer reaching TURN_CYCLES-1 -> toggle cur_player, pulse err_pulse, clear timer, stay in TURN.
REQ-037 Macro undefined: no timer logic; TURN waits indefinitely.

Verification (N=5, SHIPS=3, TURN_CYCLES=16)
REQ-038 P0 places (0,0),(0,1),(0,2); P1 places (4,4),(3,3),(2,2) -> state TURN, ships_p0=ships_p1=3.
REQ-039 P0 places (0,0) twice, then (5,1) -> err_pulse twice; ships_p0=1.
REQ-040 P0 fires (4,4) -> hit_feedback 2 cycles later, ships_p1=2, cur_player stays 0; P0 fires (1,1) -> miss_feedback, cur_player=1.
REQ-041 P0 hits (4,4),(3,3),(2,2) in sequence -> GAME_OVER, winner=0, game_over=1; a following fire is ignored.
REQ-042 Timeout enabled, no fire for 16 cycles in TURN -> err_pulse and cur_player toggles; re-firing a used cell -> err_pulse.
REQ-043 rst asserted during RESOLVE -> state_o=0 with no feedback pulse; next game starts with counts 0.
